wb_rr_arbiter: RTL
==================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 2: number of Wishbone masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width. SEL width is DATA_W/8.
REQ-004 SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin, 1 selects fixed priority with master 0 highest.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 255: slave-ack timeout in cycles; 0 disables the timeout.
REQ-006 SHALL have the following ports; one clock; reset is synchronous and active-high:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- m_cyc_i  in  NUM_M  per-master cycle.
- m_stb_i  in  NUM_M  per-master strobe.
- m_we_i  in  NUM_M  per-master write enable.
- m_sel_i  in  NUM_M*DATA_W/8  flattened byte selects; master k at slice k.
- m_adr_i  in  NUM_M*ADDR_W  flattened addresses.
- m_dat_i  in  NUM_M*DATA_W  flattened write data.
- m_ack_o  out  NUM_M  per-master ack.
- m_err_o  out  NUM_M  per-master timeout error.
- m_dat_o  out  DATA_W  read data, broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls.
- s_sel_o  out  DATA_W/8  slave-side byte selects.
- s_adr_o  out  ADDR_W  slave-side address.
- s_dat_o  out  DATA_W  slave-side write data.
- s_ack_i  in  1  slave ack.
- s_dat_i  in  DATA_W  slave read data.
- grant_o  out  NUM_M  one-hot registered grant.
- busy_o  out  1  high when the state is not IDLE.

Function
REQ-007 SHALL implement a registered FSM with states IDLE, GRANT and ERR.
REQ-008 In IDLE with no m_cyc_i bit set, SHALL stay in IDLE with grant_o=0.
REQ-009 In IDLE with any m_cyc_i bit set, SHALL select a winner and load grant_o on the next edge (1-cycle arbitration latency), then enter GRANT.
REQ-010 In fixed mode, SHALL grant the lowest-index requesting master.
REQ-011 In round-robin mode, SHALL search upward from index rr_ptr with wrap-around from NUM_M-1 to 0, granting the first requester found.
REQ-012 On entering GRANT, SHALL set rr_ptr to (winner+1) mod NUM_M; rr_ptr SHALL reset to 0.
REQ-013 In GRANT, SHALL route the granted master's cyc, stb, we, sel, adr and dat combinationally to the s_* outputs.
REQ-014 When grant_o=0, all s_* outputs SHALL be 0.
REQ-015 In GRANT, SHALL route m_ack_o[g]=s_ack_i & m_stb_i[g] for granted master g only; all other ack bits SHALL stay 0.
REQ-016 SHALL drive m_dat_o=s_dat_i at all times.
REQ-017 SHALL hold the grant across multiple stb transfers while m_cyc_i[g] stays high; no preemption, even by a higher-priority master.
REQ-018 When m_cyc_i[g]=0 in GRANT, SHALL clear grant_o and return to IDLE; this guarantees at least one IDLE cycle between grants.
REQ-019 SHALL keep a timeout counter (width clog2(TIMEOUT_CYC+1)) that increments each GRANT cycle with s_stb_o=1 and s_ack_i=0.
REQ-020 The timeout counter SHALL clear on ack, on leaving GRANT, and whenever stb=0.
REQ-021 When the counter equals TIMEOUT_CYC (TIMEOUT_CYC>0), SHALL enter ERR on the next edge.
REQ-022 In ERR, SHALL pulse m_err_o[g]=1 for exactly one cycle with s_cyc_o=s_stb_o=0, keep grant_o, then return to GRANT with the counter at 0.
REQ-023 If s_ack_i arrives in the same cycle the counter reaches TIMEOUT_CYC, the ack SHALL win: ack passed through, counter cleared, no ERR.
REQ-024 If m_cyc_i[g] drops while in ERR, SHALL still emit the err pulse, then go to IDLE.
REQ-025 m_ack_o and m_err_o SHALL never be high in the same cycle.

Reset
REQ-026 While wb_rst_i is high at a clock edge, SHALL set state=IDLE, grant_o=0, rr_ptr=0 and counter=0.
REQ-027 During reset, SHALL drive all s_* outputs, m_ack_o and m_err_o to 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no ack or err emitted.
REQ-029 After reset release, SHALL resume arbitration starting from IDLE.

Verification
REQ-030 NUM_M=2, round-robin; both masters hold cyc continuously, each doing 1 transfer then dropping cyc for 1 cycle -> grants alternate 0,1,0,1 with one IDLE cycle between.
REQ-031 NUM_M=4, FIXED_PRIO=1; masters 1 and 3 request together -> master 1 is granted first, master 3 after master 1 drops cyc.
REQ-032 Master 0 holds cyc for 3 transfers (adr 0x30000000, 0x30000004, 0x30000008) while master 1 requests -> master 1 gets no grant until master 0 drops cyc; acks reach master 0 only.
REQ-033 TIMEOUT_CYC=4 and the slave never acks -> m_err_o[g] pulses for 1 cycle after 5 stalled stb cycles; the ERR cycle has s_cyc_o=0; no ack is issued.
REQ-034 TIMEOUT_CYC=4 and s_ack_i arrives exactly when the counter reaches 4 -> ack delivered, no err.
REQ-035 wb_rst_i asserted for 1 cycle during a granted write -> next cycle grant_o=0, s_cyc_o=0, rr_ptr=0, no ack or err pulse.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Wishbone N-master to single-slave arbiter with round-robin or fixed priority,
// grant held for the whole cycle, and a slave-ack timeout that reports an error pulse.
module wb_rr_arbiter #(
  parameter int NUM_M       = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIXED_PRIO  = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [NUM_M-1:0]           m_cyc_i,
  input  logic [NUM_M-1:0]           m_stb_i,
  input  logic [NUM_M-1:0]           m_we_i,
  input  logic [NUM_M*DATA_W/8-1:0]  m_sel_i,
  input  logic [NUM_M*ADDR_W-1:0]    m_adr_i,
  input  logic [NUM_M*DATA_W-1:0]    m_dat_i,
  output logic [NUM_M-1:0]           m_ack_o,
  output logic [NUM_M-1:0]           m_err_o,
  output logic [DATA_W-1:0]          m_dat_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [DATA_W/8-1:0]        s_sel_o,
  output logic [ADDR_W-1:0]          s_adr_o,
  output logic [DATA_W-1:0]          s_dat_o,
  input  logic                       s_ack_i,
  input  logic [DATA_W-1:0]          s_dat_i,
  output logic [NUM_M-1:0]           grant_o,
  output logic                       busy_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = $clog2(NUM_M);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_M-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_M-1:0]   win_oh;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   win_nxt;
  logic               found_v;
  logic [PTR_W:0]     sum_v;
  logic [PTR_W-1:0]   cand_v;

  logic               g_cyc, g_stb, g_we;
  logic [SEL_W-1:0]   g_sel;
  logic [ADDR_W-1:0]  g_adr;
  logic [DATA_W-1:0]  g_dat;
  logic               in_grant, in_err;

  // State, grant, pointer and timeout counter registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Winner search: from index 0 in fixed mode, from rr_ptr with wrap otherwise
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found_v = 1'b0;
    sum_v   = '0;
    cand_v  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (FIXED_PRIO != 0) begin
        sum_v = (PTR_W+1)'(i);
      end else begin
        sum_v = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      end
      if (sum_v >= (PTR_W+1)'(NUM_M)) begin
        cand_v = PTR_W'(sum_v - (PTR_W+1)'(NUM_M));
      end else begin
        cand_v = sum_v[PTR_W-1:0];
      end
      if (!found_v && m_cyc_i[cand_v]) begin
        found_v         = 1'b1;
        win_oh[cand_v]  = 1'b1;
        win_idx         = cand_v;
      end else begin
        found_v = found_v;
      end
    end
    if (win_idx == PTR_W'(NUM_M - 1)) begin
      win_nxt = '0;
    end else begin
      win_nxt = win_idx + PTR_W'(1);
    end
  end

  // One-hot mux of the granted master's bus signals
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (grant_q[k]) begin
        g_cyc = m_cyc_i[k];
        g_stb = m_stb_i[k];
        g_we  = m_we_i[k];
        g_sel = m_sel_i[k*SEL_W +: SEL_W];
        g_adr = m_adr_i[k*ADDR_W +: ADDR_W];
        g_dat = m_dat_i[k*DATA_W +: DATA_W];
      end else begin
        g_cyc = g_cyc;
      end
    end
  end

  // Next-state logic; a dropped cyc beats the timeout, and an ack beats the timeout
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|m_cyc_i) begin
          state_d  = S_GRANT;
          grant_d  = win_oh;
          rr_ptr_d = win_nxt;
        end else begin
          grant_d = '0;
        end
      end
      S_GRANT: begin
        if (!g_cyc) begin
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (!g_stb || s_ack_i) begin
          cnt_d = '0;
        end else if ((TIMEOUT_CYC > 0) && (cnt_q == TO_VAL)) begin
          state_d = S_ERR;
          cnt_d   = '0;
        end else if (TIMEOUT_CYC > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      S_ERR: begin
        cnt_d = '0;
        if (g_cyc) begin
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs; reset forces the slave side and the ack/err lines quiet in the same cycle
  always_comb begin
    in_grant = (state_q == S_GRANT) && !wb_rst_i;
    in_err   = (state_q == S_ERR) && !wb_rst_i;
    s_cyc_o  = in_grant & g_cyc;
    s_stb_o  = in_grant & g_stb;
    s_we_o   = in_grant & g_we;
    if (in_grant) begin
      s_sel_o = g_sel;
      s_adr_o = g_adr;
      s_dat_o = g_dat;
      m_ack_o = grant_q & m_stb_i & {NUM_M{s_ack_i}};
    end else begin
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
    end
    if (in_err) begin
      m_err_o = grant_q;
    end else begin
      m_err_o = '0;
    end
    m_dat_o = s_dat_i;
    grant_o = grant_q;
    busy_o  = (state_q != S_IDLE);
  end

endmodule
